// File: rtl/tff_updown_counter.sv
// Up/down modulo counter built as a bank of falling-edge T flip-flops with async clear/preset,
// parallel load with clamp, wrap or saturate at the limits, terminal-count and overflow flags.
module tff_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pst,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;

    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_load;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_limit;

    assign w_at_max = (r_q == MAX);
    assign w_at_min = (r_q == '0);
    assign w_limit  = up ? w_at_max : w_at_min;

    // Out-of-range load values are clamped to the top of the count range.
    assign w_load = ({1'b0, d} >= (WIDTH+1)'(MODULUS)) ? MAX : d;

    always_comb begin
        w_q_next = r_q;
        if (ld) begin
            w_q_next = w_load;
        end else if (en) begin
            if (up) begin
                if (!w_at_max)
                    w_q_next = r_q + WIDTH'(1);
                else if (SATURATE == 0)
                    w_q_next = '0;
            end else begin
                if (!w_at_min)
                    w_q_next = r_q - WIDTH'(1);
                else if (SATURATE == 0)
                    w_q_next = MAX;
            end
        end
    end

    // Per-bit toggle enables: each flop toggles exactly where the next value differs.
    assign w_t = r_q ^ w_q_next;

    always_ff @(negedge clk or negedge clr or negedge pst) begin
        if (!clr) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
        end else if (!pst) begin
            r_q   <= MAX;
            r_ovf <= 1'b0;
        end else begin
            r_q   <= r_q ^ w_t;
            r_ovf <= en & ~ld & w_limit;
        end
    end

    assign tc    = en & ~ld & w_limit;
    assign q     = r_q;
    assign q_bar = ~r_q;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Directed bench for tff_updown_counter: three configurations (wrap/10, saturate/10, wrap/8 in 3 bits)
// share stimulus; expected states are pushed to a scoreboard queue and popped after each falling edge.
module tb_tff_updown_counter;

    logic       clk;
    logic       clr;
    logic       pst;
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] d;

    logic [3:0] q_a, qb_a, q_s, qb_s;
    logic [2:0] q_b, qb_b;
    logic       tc_a, tc_s, tc_b, ovf_a, ovf_s, ovf_b;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int qa; int qs; int qb;
        bit oa; bit os; bit ob;
    } exp_t;
    exp_t sb[$];

    // model state
    int mq_a, mq_s, mq_b;
    bit mo_a, mo_s, mo_b;

    tff_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_a (
        .clk(clk), .clr(clr), .pst(pst), .en(en), .up(up), .ld(ld), .d(d),
        .q(q_a), .q_bar(qb_a), .tc(tc_a), .ovf(ovf_a));

    tff_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
        .clk(clk), .clr(clr), .pst(pst), .en(en), .up(up), .ld(ld), .d(d),
        .q(q_s), .q_bar(qb_s), .tc(tc_s), .ovf(ovf_s));

    tff_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) dut_b (
        .clk(clk), .clr(clr), .pst(pst), .en(en), .up(up), .ld(ld), .d(d[2:0]),
        .q(q_b), .q_bar(qb_b), .tc(tc_b), .ovf(ovf_b));

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_tests++;
        assert (obs === 32'(exp)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit lim(int q, bit e, bit u, bit l, int mod);
        return e && !l && ((u && q == mod - 1) || (!u && q == 0));
    endfunction

    function automatic int nxt(int q, bit e, bit u, bit l, int dv, int mod, bit sat);
        if (l) return (dv >= mod) ? mod - 1 : dv;
        if (!e) return q;
        if (u) return (q == mod - 1) ? (sat ? q : 0) : q + 1;
        return (q == 0) ? (sat ? q : mod - 1) : q - 1;
    endfunction

    task automatic chk_all(input string tag);
        chk({tag, ".q_a"},   q_a,   mq_a);
        chk({tag, ".qb_a"},  qb_a,  (~mq_a) & 15);
        chk({tag, ".ovf_a"}, ovf_a, mo_a);
        chk({tag, ".q_s"},   q_s,   mq_s);
        chk({tag, ".qb_s"},  qb_s,  (~mq_s) & 15);
        chk({tag, ".ovf_s"}, ovf_s, mo_s);
        chk({tag, ".q_b"},   q_b,   mq_b);
        chk({tag, ".qb_b"},  qb_b,  (~mq_b) & 7);
        chk({tag, ".ovf_b"}, ovf_b, mo_b);
    endtask

    // Called just after a rising edge; applies inputs, checks tc, then checks the falling-edge result.
    task automatic step(input string tag, input bit e, input bit u, input bit l, input int dv);
        exp_t x;
        en = e; up = u; ld = l; d = 4'(dv);
        #1;
        chk({tag, ".tc_a"}, tc_a, lim(mq_a, e, u, l, 10));
        chk({tag, ".tc_s"}, tc_s, lim(mq_s, e, u, l, 10));
        chk({tag, ".tc_b"}, tc_b, lim(mq_b, e, u, l, 8));
        x.qa = nxt(mq_a, e, u, l, dv, 10, 1'b0);
        x.qs = nxt(mq_s, e, u, l, dv, 10, 1'b1);
        x.qb = nxt(mq_b, e, u, l, dv & 7, 8, 1'b0);
        x.oa = lim(mq_a, e, u, l, 10);
        x.os = lim(mq_s, e, u, l, 10);
        x.ob = lim(mq_b, e, u, l, 8);
        sb.push_back(x);
        @(negedge clk);
        #1;
        x = sb.pop_front();
        mq_a = x.qa; mq_s = x.qs; mq_b = x.qb;
        mo_a = x.oa; mo_s = x.os; mo_b = x.ob;
        chk_all(tag);
        @(posedge clk);
    endtask

    task automatic model_set(input int va, input int vs, input int vb);
        mq_a = va; mq_s = vs; mq_b = vb;
        mo_a = 1'b0; mo_s = 1'b0; mo_b = 1'b0;
    endtask

    // Async clear mid-cycle, held across a falling edge with en high, released at a rising edge.
    task automatic clr_pulse(input string tag);
        en = 1'b1; up = 1'b1; ld = 1'b0;
        #2;
        clr = 1'b0;
        #1;
        model_set(0, 0, 0);
        chk_all({tag, ".async"});
        @(negedge clk);
        #1;
        chk_all({tag, ".held"});
        @(posedge clk);
        clr = 1'b1;
    endtask

    initial begin
        clr = 1'b0; pst = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; d = '0;
        #2;
        model_set(0, 0, 0);
        chk_all("reset");
        @(posedge clk);
        clr = 1'b1;

        // count up through the wrap
        for (int i = 0; i < 12; i++) step("up", 1'b1, 1'b1, 1'b0, 0);

        clr_pulse("clr1");

        // down from zero: wrap vs saturate, ovf held while saturated
        for (int i = 0; i < 3; i++) step("down", 1'b1, 1'b0, 1'b0, 0);

        // async clear while the saturated counter's ovf is high
        clr_pulse("clr2");

        // load with clamp, load overriding count, then hold
        step("ld13", 1'b0, 1'b0, 1'b1, 13);
        step("ld5",  1'b1, 1'b1, 1'b1, 5);
        step("hold", 1'b0, 1'b1, 1'b0, 0);

        // preset mid-cycle at q=3, then clr together with pst
        step("ld2", 1'b0, 1'b1, 1'b1, 2);
        step("to3", 1'b1, 1'b1, 1'b0, 0);
        #2;
        pst = 1'b0;
        #1;
        model_set(9, 9, 7);
        chk_all("pst");
        clr = 1'b0;
        #1;
        model_set(0, 0, 0);
        chk_all("pst_clr");
        @(negedge clk);
        #1;
        chk_all("pst_clr_held");
        @(posedge clk);
        pst = 1'b1; clr = 1'b1;
        step("resume", 1'b1, 1'b1, 1'b0, 0);
        step("resume2", 1'b1, 1'b1, 1'b0, 0);

        // clear between edges at q=7
        step("ld6", 1'b0, 1'b1, 1'b1, 6);
        step("to7", 1'b1, 1'b1, 1'b0, 0);
        clr_pulse("clr7");

        // alternating direction, with limit crossings on the 3-bit counter
        step("alt_ld6", 1'b0, 1'b1, 1'b1, 6);
        for (int i = 0; i < 4; i++) step("alt", 1'b1, 1'(i % 2 == 0), 1'b0, 0);
        step("alt_x1", 1'b1, 1'b1, 1'b0, 0);
        step("alt_x2", 1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) step("alt0", 1'b1, 1'(i % 2 == 0), 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
